// File: rtl/irq_dispatch_ctrl.sv
// irq_dispatch_ctrl: SM83 interrupt-dispatch sequencer.
// Detects an enabled pending interrupt at an instruction boundary, pushes PC
// (high byte first) onto the stack over M2..M4 and loads the vector in M5.
// t_phase encoding: T1=2'd0, T2=2'd1, T3=2'd2, T4=2'd3.
// Optional build macro IRQ_CANCEL_EN: re-resolve the source after the
// high-byte push; if nothing is pending any more, jump to 0x0000 unacknowledged.
module irq_dispatch_ctrl #(
    parameter int unsigned NUM_IRQ       = 5,
    parameter logic [15:0] VECTOR_BASE   = 16'h0040,
    parameter int unsigned VECTOR_STRIDE = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         t_phase,
    input  logic               instr_boundary,
    input  logic               halted,
    input  logic               ime,
    input  logic [NUM_IRQ-1:0] ie,
    input  logic [NUM_IRQ-1:0] if_flags,
    input  logic [15:0]        pc,
    input  logic [15:0]        sp,
    output logic               dispatch_active,
    output logic               halt_exit,
    output logic               ime_clr,
    output logic [NUM_IRQ-1:0] if_ack,
    output logic               sp_we,
    output logic [15:0]        sp_next,
    output logic               mem_we,
    output logic [15:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               pc_we,
    output logic [15:0]        pc_next
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [1:0]  PH_T3 = 2'd2;
    localparam logic [1:0]  PH_T4 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M1   = 3'd1,
        ST_M2   = 3'd2,
        ST_M3   = 3'd3,
        ST_M4   = 3'd4,
        ST_M5   = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [15:0]        pc_lat_q;
    logic [15:0]        vec_q;
    logic [IDX_W-1:0]   idx_q;
    logic               ack_valid_q;
    logic               halt_fired_q;

    logic [NUM_IRQ-1:0] pending;
    logic               pend_any;
    logic [IDX_W-1:0]   pend_idx;
    logic               is_t3;
    logic               is_t4;
    logic               accept;

    function automatic logic [15:0] vector_of(input logic [IDX_W-1:0] i);
        return VECTOR_BASE + (16'(i) * 16'(VECTOR_STRIDE));
    endfunction

    assign pending  = ie & if_flags;
    assign pend_any = |pending;
    assign is_t3    = (t_phase == PH_T3);
    assign is_t4    = (t_phase == PH_T4);
    assign accept   = reset_n && instr_boundary && is_t4 && ime && pend_any;

    // Priority encoder: lowest set pending bit wins.
    always_comb begin
        pend_idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (pending[i]) pend_idx = IDX_W'(i);
        end
    end

    // State register; advances only when the next-state logic says so (T4).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Latched dispatch context: return PC, serviced source, vector, halt wake guard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_lat_q     <= '0;
            vec_q        <= '0;
            idx_q        <= '0;
            ack_valid_q  <= 1'b0;
            halt_fired_q <= 1'b0;
        end else begin
            halt_fired_q <= halted && pend_any;
            if (state_q == ST_IDLE && accept) begin
                pc_lat_q    <= pc;
                idx_q       <= pend_idx;
                ack_valid_q <= 1'b1;
            end
            if (state_q == ST_M4 && is_t3) begin
`ifdef IRQ_CANCEL_EN
                idx_q       <= pend_idx;
                ack_valid_q <= pend_any;
                vec_q       <= pend_any ? vector_of(pend_idx) : 16'h0000;
`else
                vec_q       <= vector_of(idx_q);
`endif
            end
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d         = state_q;
        dispatch_active = 1'b0;
        halt_exit       = 1'b0;
        ime_clr         = 1'b0;
        if_ack          = '0;
        sp_we           = 1'b0;
        sp_next         = '0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        pc_we           = 1'b0;
        pc_next         = '0;
        case (state_q)
            ST_IDLE: begin
                halt_exit = reset_n && halted && pend_any && !halt_fired_q;
                if (accept) begin
                    ime_clr = 1'b1;
                    state_d = ST_M1;
                end
            end
            ST_M1: begin
                dispatch_active = 1'b1;
                if (is_t4) state_d = ST_M2;
            end
            ST_M2: begin
                dispatch_active = 1'b1;
                if (is_t4) begin
                    sp_we   = 1'b1;
                    sp_next = sp - 16'd1;
                    state_d = ST_M3;
                end
            end
            ST_M3: begin
                dispatch_active = 1'b1;
                mem_addr        = sp;
                mem_wdata       = pc_lat_q[15:8];
                mem_we          = is_t3;
                if (is_t4) begin
                    sp_we   = 1'b1;
                    sp_next = sp - 16'd1;
                    state_d = ST_M4;
                end
            end
            ST_M4: begin
                dispatch_active = 1'b1;
                mem_addr        = sp;
                mem_wdata       = pc_lat_q[7:0];
                mem_we          = is_t3;
                if (is_t4) state_d = ST_M5;
            end
            ST_M5: begin
                dispatch_active = 1'b1;
                pc_next         = vec_q;
                if (is_t4) begin
                    pc_we   = 1'b1;
                    if_ack  = ack_valid_q ? (NUM_IRQ'(1) << idx_q) : '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
